// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared word format, write-FSM states and a saturating counter helper
package eth_pkg;

  localparam int WORD_W = 34;

  typedef struct packed {
    logic        eop;
    logic        sop;
    logic [31:0] data;
  } eth_word_t;

  typedef enum logic [1:0] {W_IDLE, W_PKT, W_DROP} wr_state_t;

  function automatic logic [15:0] sat_add16(input logic [15:0] v, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, v} + {15'd0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/eth_fifo_mem.sv
// rtl/eth_fifo_mem.sv - DEPTH x WORD_W simple dual-port RAM, synchronous write, asynchronous read
module eth_fifo_mem
  import eth_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  eth_word_t     wr_data,
  input  logic [AW-1:0] rd_addr,
  output eth_word_t     rd_data
);

  eth_word_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/eth_pkt_fifo.sv
// rtl/eth_pkt_fifo.sv - store-and-forward packet buffer; only committed packets reach the read side
module eth_pkt_fifo
  import eth_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int PTR_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_wr_en,
  input  logic [33:0]       in_data,
  input  logic              out_rd_en,
  output logic              out_valid,
  output logic [33:0]       out_data,
  output logic              pkt_avail,
  output logic [PTR_W-1:0]  pkt_count,
  output logic [15:0]       drop_count,
  output logic [15:0]       err_count
);

  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_DEPTH = PTR_W'(DEPTH);

  wr_state_t        state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] wr_ptr_c_q, wr_ptr_c_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] pkt_count_q, pkt_count_d;
  logic [15:0]      drop_q, drop_d;
  logic [15:0]      err_q, err_d;

  eth_word_t        in_word, head_word;
  logic             mem_we, start, commit, pop, err_inc;
  logic [PTR_W-1:0] mem_ptr;
  logic [1:0]       drop_inc;

  assign in_word = in_data;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    mem_we   = 1'b0;
    mem_ptr  = wr_ptr_q;
    start    = 1'b0;
    commit   = 1'b0;
    drop_inc = 2'd0;
    err_inc  = 1'b0;
    pop      = out_rd_en && out_valid;

    if (in_wr_en) begin
      case (state_q)
        W_IDLE: begin
          if (in_word.sop) start   = 1'b1;
          else             err_inc = 1'b1;
        end
        W_PKT: begin
          if (in_word.sop) begin
            drop_inc = 2'd1;
            start    = 1'b1;
          end else if ((wr_ptr_q - rd_ptr_q) == PTR_DEPTH) begin
            drop_inc = 2'd1;
            wr_ptr_d = wr_ptr_c_q;
            state_d  = in_word.eop ? W_IDLE : W_DROP;
          end else begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (in_word.eop) begin
              commit  = 1'b1;
              state_d = W_IDLE;
            end
          end
        end
        W_DROP: begin
          if (in_word.sop)      start   = 1'b1;
          else if (in_word.eop) state_d = W_IDLE;
        end
        default: state_d = W_IDLE;
      endcase

      // A new packet always starts at the committed pointer, which also rewinds a truncated one.
      if (start) begin
        if ((wr_ptr_c_q - rd_ptr_q) == PTR_DEPTH) begin
          drop_inc = drop_inc + 2'd1;
          wr_ptr_d = wr_ptr_c_q;
          state_d  = in_word.eop ? W_IDLE : W_DROP;
        end else begin
          mem_we   = 1'b1;
          mem_ptr  = wr_ptr_c_q;
          wr_ptr_d = wr_ptr_c_q + PTR_ONE;
          commit   = in_word.eop;
          state_d  = in_word.eop ? W_IDLE : W_PKT;
        end
      end
    end

    wr_ptr_c_d = commit ? wr_ptr_d : wr_ptr_c_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    pkt_count_d = pkt_count_q;
    if (commit && !(pop && head_word.eop))      pkt_count_d = pkt_count_q + PTR_ONE;
    else if (!commit && pop && head_word.eop)   pkt_count_d = pkt_count_q - PTR_ONE;

    drop_d = sat_add16(drop_q, drop_inc);
    err_d  = sat_add16(err_q, {1'b0, err_inc});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= W_IDLE;
      wr_ptr_q    <= '0;
      wr_ptr_c_q  <= '0;
      rd_ptr_q    <= '0;
      pkt_count_q <= '0;
      drop_q      <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_ptr_c_q  <= wr_ptr_c_d;
      rd_ptr_q    <= rd_ptr_d;
      pkt_count_q <= pkt_count_d;
      drop_q      <= drop_d;
      err_q       <= err_d;
    end
  end

  eth_fifo_mem #(.DEPTH(DEPTH), .AW(PTR_W-1)) u_mem (
    .clk     (clk),
    .wr_en   (mem_we),
    .wr_addr (mem_ptr[PTR_W-2:0]),
    .wr_data (in_word),
    .rd_addr (rd_ptr_q[PTR_W-2:0]),
    .rd_data (head_word)
  );

  assign out_valid  = (rd_ptr_q != wr_ptr_c_q);
  assign out_data   = head_word;
  assign pkt_avail  = (pkt_count_q != '0);
  assign pkt_count  = pkt_count_q;
  assign drop_count = drop_q;
  assign err_count  = err_q;

endmodule

// File: tb/tb_eth_pkt_fifo.sv
// tb/tb_eth_pkt_fifo.sv - directed vector table plus hand sequences for overflow, wrap and reset
module tb_eth_pkt_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_wr_en;
  logic [33:0] in_data;
  logic        out_rd_en;
  logic        out_valid;
  logic [33:0] out_data;
  logic        pkt_avail;
  logic [3:0]  pkt_count;
  logic [15:0] drop_count;
  logic [15:0] err_count;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [33:0] din;
    logic        exp_valid;
    logic [33:0] exp_data;
    logic [3:0]  exp_pkt;
    logic [15:0] exp_drop;
    logic [15:0] exp_err;
  } vec_t;

  vec_t tbl[$];

  eth_pkt_fifo #(.DEPTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_wr_en   (in_wr_en),
    .in_data    (in_data),
    .out_rd_en  (out_rd_en),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .pkt_avail  (pkt_avail),
    .pkt_count  (pkt_count),
    .drop_count (drop_count),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [33:0] w(input logic e, input logic s, input logic [31:0] d);
    return {e, s, d};
  endfunction

  function automatic void add(input logic wr, input logic rd, input logic [33:0] din,
                              input logic ev, input logic [33:0] ed, input logic [3:0] ep,
                              input logic [15:0] edr, input logic [15:0] eer);
    tbl.push_back('{wr, rd, din, ev, ed, ep, edr, eer});
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic wr, input logic [33:0] d, input logic rd);
    in_wr_en  = wr;
    in_data   = d;
    out_rd_en = rd;
    @(posedge clk);
    #1;
    in_wr_en  = 1'b0;
    out_rd_en = 1'b0;
  endtask

  initial begin
    logic [33:0] expq[$];
    logic [33:0] d;
    int popped;

    // single packet, one-word packet, stray words, truncated packet
    add(1, 0, w(0,1,32'h1),  0, '0,          4'd0, 16'd0, 16'd0);
    add(1, 0, w(0,0,32'h2),  0, '0,          4'd0, 16'd0, 16'd0);
    add(1, 0, w(0,0,32'h3),  0, '0,          4'd0, 16'd0, 16'd0);
    add(1, 0, w(1,0,32'h4),  1, w(0,1,32'h1), 4'd1, 16'd0, 16'd0);
    add(0, 1, '0,            1, w(0,0,32'h2), 4'd1, 16'd0, 16'd0);
    add(0, 1, '0,            1, w(0,0,32'h3), 4'd1, 16'd0, 16'd0);
    add(0, 1, '0,            1, w(1,0,32'h4), 4'd1, 16'd0, 16'd0);
    add(0, 1, '0,            0, '0,          4'd0, 16'd0, 16'd0);
    add(1, 0, w(1,1,32'hAA), 1, w(1,1,32'hAA), 4'd1, 16'd0, 16'd0);
    add(0, 1, '0,            0, '0,          4'd0, 16'd0, 16'd0);
    add(1, 0, w(0,0,32'h55), 0, '0,          4'd0, 16'd0, 16'd1);
    add(1, 0, w(0,0,32'h56), 0, '0,          4'd0, 16'd0, 16'd2);
    add(1, 0, w(1,0,32'h57), 0, '0,          4'd0, 16'd0, 16'd3);
    add(1, 0, w(0,1,32'h10), 0, '0,          4'd0, 16'd0, 16'd3);
    add(1, 0, w(0,0,32'h11), 0, '0,          4'd0, 16'd0, 16'd3);
    add(1, 0, w(0,1,32'h20), 0, '0,          4'd0, 16'd1, 16'd3);
    add(1, 0, w(0,0,32'h21), 0, '0,          4'd0, 16'd1, 16'd3);
    add(1, 0, w(1,0,32'h22), 1, w(0,1,32'h20), 4'd1, 16'd1, 16'd3);
    add(0, 1, '0,            1, w(0,0,32'h21), 4'd1, 16'd1, 16'd3);
    add(0, 1, '0,            1, w(1,0,32'h22), 4'd1, 16'd1, 16'd3);
    add(0, 1, '0,            0, '0,          4'd0, 16'd1, 16'd3);
    add(0, 1, '0,            0, '0,          4'd0, 16'd1, 16'd3);

    rst = 1'b1; in_wr_en = 1'b0; in_data = '0; out_rd_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_avail", 64'(pkt_avail), 0);
    chk("rst_pkt",   64'(pkt_count), 0);
    chk("rst_drop",  64'(drop_count), 0);
    chk("rst_err",   64'(err_count), 0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].wr, tbl[i].din, tbl[i].rd);
      chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) chk($sformatf("v%0d_data", i), 64'(out_data), 64'(tbl[i].exp_data));
      chk($sformatf("v%0d_pkt", i),   64'(pkt_count),  64'(tbl[i].exp_pkt));
      chk($sformatf("v%0d_avail", i), 64'(pkt_avail),  64'(tbl[i].exp_pkt != 0));
      chk($sformatf("v%0d_drop", i),  64'(drop_count), 64'(tbl[i].exp_drop));
      chk($sformatf("v%0d_err", i),   64'(err_count),  64'(tbl[i].exp_err));
    end

    // 10-word packet into an 8-deep buffer is dropped whole
    for (int i = 0; i < 10; i++) begin
      step(1'b1, w(i == 9, i == 0, 32'(32'h100 + i)), 1'b0);
      chk($sformatf("ovf_valid%0d", i), 64'(out_valid), 0);
    end
    chk("ovf_drop", 64'(drop_count), 2);
    chk("ovf_pkt",  64'(pkt_count), 0);
    for (int i = 0; i < 3; i++) step(1'b1, w(i == 2, i == 0, 32'(32'h200 + i)), 1'b0);
    chk("post_ovf_pkt", 64'(pkt_count), 1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("post_ovf_data%0d", i), 64'(out_data), 64'(w(i == 2, i == 0, 32'(32'h200 + i))));
      step(1'b0, '0, 1'b1);
    end
    chk("post_ovf_valid", 64'(out_valid), 0);

    // packet of exactly DEPTH words fits
    for (int i = 0; i < 8; i++) step(1'b1, w(i == 7, i == 0, 32'(32'h300 + i)), 1'b0);
    chk("fit_pkt",  64'(pkt_count), 1);
    chk("fit_drop", 64'(drop_count), 2);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("fit_data%0d", i), 64'(out_data), 64'(w(i == 7, i == 0, 32'(32'h300 + i))));
      step(1'b0, '0, 1'b1);
    end
    chk("fit_empty", 64'(out_valid), 0);

    // back-to-back 3-word packets with concurrent pops, wrapping the pointers
    popped = 0;
    for (int p = 0; p < 20; p++) begin
      for (int k = 0; k < 3; k++) begin
        logic rd;
        d = w(k == 2, k == 0, 32'(32'h1000 + p * 3 + k));
        rd = out_valid;
        if (rd) begin
          chk($sformatf("conc_data%0d", popped), 64'(out_data), 64'(expq.pop_front()));
          popped++;
        end
        expq.push_back(d);
        step(1'b1, d, rd);
      end
    end
    for (int c = 0; c < 40 && out_valid; c++) begin
      chk($sformatf("conc_data%0d", popped), 64'(out_data), 64'(expq.pop_front()));
      popped++;
      step(1'b0, '0, 1'b1);
    end
    chk("conc_popped", 64'(popped), 60);
    chk("conc_drop",   64'(drop_count), 2);
    chk("conc_pkt",    64'(pkt_count), 0);
    chk("conc_valid",  64'(out_valid), 0);

    // reset in the middle of a packet flushes everything
    step(1'b1, w(1,1,32'hB0), 1'b0);
    step(1'b1, w(0,1,32'hC0), 1'b0);
    step(1'b1, w(0,0,32'hC1), 1'b0);
    chk("pre_rst_valid", 64'(out_valid), 1);
    rst = 1'b1;
    step(1'b1, w(0,0,32'hC2), 1'b0);
    rst = 1'b0;
    chk("mid_rst_valid", 64'(out_valid), 0);
    chk("mid_rst_pkt",   64'(pkt_count), 0);
    chk("mid_rst_drop",  64'(drop_count), 0);
    chk("mid_rst_err",   64'(err_count), 0);
    step(1'b1, w(1,0,32'hC3), 1'b0);
    chk("post_rst_stray", 64'(err_count), 1);
    chk("post_rst_valid", 64'(out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/eth_pkt_fifo.md
# eth_pkt_fifo

Store-and-forward packet buffer directly downstream of the Ethernet receive FSM. It accepts 34-bit words {eop, sop, data[31:0]} on a write strobe and stores them in a circular buffer. Only complete packets are exposed to the read side, which feeds the switch output-port arbiter. Packets that overflow the buffer or arrive malformed are discarded whole, and each discard is counted.

## Interface
- DEPTH, 64, buffer depth in words; power of two, at least 4
- PTR_W, $clog2(DEPTH)+1, pointer width including the wrap bit
- clk  in  1  sole clock; all logic on the rising edge
- rst  in  1  reset, synchronous, active-high
- in_wr_en  in  1  in_data valid this cycle
- in_data  in  34  [33]=eop, [32]=sop, [31:0]=payload
- out_rd_en  in  1  pop head word; ignored when out_valid=0
- out_valid  out  1  committed word available at head
- out_data  out  34  head word, same format as in_data
- pkt_avail  out  1  pkt_count != 0
- pkt_count  out  PTR_W  complete packets stored
- drop_count  out  16  dropped packets; saturates at 16'hFFFF
- err_count  out  16  stray words (no sop while idle); saturates

## Operation
- Pointers: wr_ptr (working), wr_ptr_c (committed), rd_ptr. All are PTR_W wide and wrap naturally. Address = ptr[PTR_W-2:0].
- Space: used = wr_ptr - rd_ptr (modulo 2^PTR_W). Full when used == DEPTH. Uses the registered rd_ptr; a pop in the same cycle does not free space for a write in that cycle.
- Write FSM, states IDLE, PKT, DROP:
  - IDLE, write without sop: discard the word, err_count++.
  - IDLE, write with sop: store at wr_ptr and go to PKT. If eop is also set, this is a one-word packet: commit and stay in IDLE.
  - PKT, write, not full, no sop: store. If eop is set, commit and go to IDLE.
  - PKT, write while full: rewind wr_ptr to wr_ptr_c, drop_count++, go to DROP. If this word has eop, go to IDLE instead.
  - PKT, write with sop (truncated packet): rewind wr_ptr to wr_ptr_c, drop_count++, then handle the word as the sop case in IDLE, in the same cycle.
  - DROP: discard every word. eop returns to IDLE. A sop word in DROP starts a new packet as in IDLE.
- Commit: wr_ptr_c <= address of the eop word + 1, and pkt_count++.
- Read side:
  - out_valid = (rd_ptr != wr_ptr_c). out_data = mem[rd_ptr] (combinational read).
  - A pop advances rd_ptr. Popping a word with eop set decrements pkt_count.
- Commit and eop-pop in the same cycle leave pkt_count unchanged.
- Any packet longer than DEPTH words is always dropped.

## Timing
- Reset values: out_valid=0, pkt_avail=0, pkt_count=0, drop_count=0, err_count=0, all pointers=0, FSM=IDLE. out_data is undefined while out_valid=0. Reset takes effect mid-packet and flushes all stored and partial packets.
- Write to memory and FSM update occur on the same edge as in_wr_en.
- Latency: eop written at edge N gives out_valid=1 and pkt_avail=1 from cycle N+1. The first word of a packet is never visible before its eop is committed.
- Read: out_rd_en && out_valid at edge M advances the head. The next word is on out_data in cycle M+1.
- Writes are accepted every cycle; there is no backpressure. Loss is signalled only through drop_count and err_count.
- Counters saturate; they never wrap.

## Structure
- Package eth_pkg holds:
  - localparam WORD_W=34
  - typedef struct packed {logic eop; logic sop; logic [31:0] data;} eth_word_t
  - typedef enum logic [1:0] {W_IDLE, W_PKT, W_DROP} wr_state_t
- Sub-module eth_fifo_mem: simple dual-port RAM, DEPTH x WORD_W. Synchronous write, asynchronous read.
- Top-level eth_pkt_fifo holds the FSM, pointers and counters.

## Test plan
All scenarios use DEPTH=8.
- Single packet: write 4 words (sop on word 0, eop on word 3; data 0x1..0x4) -> out_valid rises the cycle after the eop write; popping returns 0x1..0x4 with matching sop/eop flags; pkt_count goes 1 -> 0.
- One-word packet: write a single word with sop and eop set, data 0xAA -> committed immediately; pkt_count=1; pops as {1,1,0xAA}.
- Overflow: write a 10-word packet with no pops -> drop_count=1, out_valid stays 0, pointers rewound; a following 3-word packet is stored and read intact.
- Truncated packet: sop, 2 words, then a new sop before any eop -> drop_count=1; only the second packet becomes visible.
- Stray words: 3 words without sop while IDLE -> err_count=3, nothing stored.
- Concurrency and wrap: continuous 3-word packets with simultaneous pops for 20 packets -> pointers wrap, no drops, data order preserved; assert rst mid-packet -> all counters and out_valid are 0 on the next cycle.
